// File: rtl/lsu_mem_access_pkg.sv
// lsu_mem_access_pkg: access-width encodings, LSU states and alignment rule
package lsu_mem_access_pkg;
  localparam logic [1:0] LSW_BYTE = 2'b00;
  localparam logic [1:0] LSW_HALF = 2'b01;
  localparam logic [1:0] LSW_WORD = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} lsu_state_e;
  function automatic logic lsu_misaligned(input logic [1:0] w, input logic [1:0] off);
    return (w == LSW_HALF && off[0]) || (w == LSW_WORD && off != 2'b00) || (w == 2'b10);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobes and load lane extraction with extension
module lsu_align
  import lsu_mem_access_pkg::*;
(
  input  logic [1:0]  i_st_width,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  input  logic [1:0]  i_ld_width,
  input  logic        i_ld_sign,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = i_rdata[{i_ld_off, 3'b000} +: 8];
    h = i_rdata[{i_ld_off[1], 4'b0000} +: 16];
    o_wdata = i_st_width == LSW_BYTE ? {4{i_st_data[7:0]}} :
              i_st_width == LSW_HALF ? {2{i_st_data[15:0]}} : i_st_data;
    o_wstrb = i_st_width == LSW_BYTE ? 4'b0001 << i_st_off :
              i_st_width == LSW_HALF ? 4'b0011 << i_st_off : 4'b1111;
    o_ldata = i_ld_width == LSW_BYTE ? {{24{i_ld_sign & b[7]}}, b} :
              i_ld_width == LSW_HALF ? {{16{i_ld_sign & h[15]}}, h} : i_rdata;
  end
endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: multi-cycle load/store unit driving one valid/ready bus access
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_Clk_1,
  input  logic        i_Rstn_1,
  input  logic        i_Load_1,
  input  logic        i_Store_1,
  input  logic        i_LoadSign_1,
  input  logic [1:0]  i_LoadStoreWidth_2,
  input  logic [31:0] i_Addr_32,
  input  logic [31:0] i_StoreData_32,
  input  logic [4:0]  i_Rd_5,
  output logic        o_Stall_1,
  output logic        o_MemReq_1,
  output logic        o_MemWe_1,
  output logic [31:0] o_MemAddr_32,
  output logic [31:0] o_MemWdata_32,
  output logic [3:0]  o_MemWstrb_4,
  input  logic        i_MemReady_1,
  input  logic [31:0] i_MemRdata_32,
  output logic        o_GRFWen_1,
  output logic [4:0]  o_GRFWriteAddr_5,
  output logic [31:0] o_GRFWriteData_32,
  output logic        o_Misalign_1,
  output logic        o_BusErr_1
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, gdata_q, gdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  width_q, width_d;
  logic [4:0]  rd_q, rd_d, gaddr_q, gaddr_d;
  logic        sign_q, sign_d, we_q, we_d, req_q, req_d;
  logic        gwen_q, gwen_d, mis_q, mis_d, berr_q, berr_d;
  logic        present, mis;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  lsu_align u_align (
    .i_st_width(i_LoadStoreWidth_2),
    .i_st_off  (i_Addr_32[1:0]),
    .i_st_data (i_StoreData_32),
    .o_wdata   (st_wdata),
    .o_wstrb   (st_wstrb),
    .i_ld_width(width_q),
    .i_ld_sign (sign_q),
    .i_ld_off  (addr_q[1:0]),
    .i_rdata   (i_MemRdata_32),
    .o_ldata   (ld_data)
  );
  assign present           = i_Load_1 | i_Store_1;
  assign mis               = lsu_misaligned(i_LoadStoreWidth_2, i_Addr_32[1:0]);
  assign o_Stall_1         = (state_q == S_IDLE && present && !mis) || state_q == S_ACCESS;
  assign o_MemReq_1        = req_q;
  assign o_MemWe_1         = we_q;
  assign o_MemAddr_32      = {addr_q[31:2], 2'b00};
  assign o_MemWdata_32     = wdata_q;
  assign o_MemWstrb_4      = wstrb_q;
  assign o_GRFWen_1        = gwen_q;
  assign o_GRFWriteAddr_5  = gaddr_q;
  assign o_GRFWriteData_32 = gdata_q;
  assign o_Misalign_1      = mis_q;
  assign o_BusErr_1        = berr_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    width_d = width_q;
    sign_d  = sign_q;
    rd_d    = rd_q;
    we_d    = we_q;
    req_d   = req_q;
    gaddr_d = gaddr_q;
    gdata_d = gdata_q;
    gwen_d  = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (present && mis) mis_d = 1'b1;
      else if (present) begin
        state_d = S_ACCESS;
        cnt_d   = 8'd0;
        req_d   = 1'b1;
        we_d    = !i_Load_1;
        addr_d  = i_Addr_32;
        wdata_d = st_wdata;
        wstrb_d = i_Load_1 ? 4'b0000 : st_wstrb;
        width_d = i_LoadStoreWidth_2;
        sign_d  = i_LoadSign_1;
        rd_d    = i_Rd_5;
      end
    end else if (state_q == S_ACCESS) begin
      // ready on the timeout edge still completes the access
      if (i_MemReady_1) begin
        state_d = S_DONE;
        req_d   = 1'b0;
        if (!we_q) begin
          gdata_d = ld_data;
          gaddr_d = rd_q;
          gwen_d  = rd_q != 5'd0;
        end
      end else if (cnt_q == CNT_LAST) begin
        state_d = S_DONE;
        req_d   = 1'b0;
        berr_d  = 1'b1;
      end else cnt_d = cnt_q + 8'd1;
    end else state_d = S_IDLE;
  end
  always_ff @(posedge i_Clk_1) begin
    if (!i_Rstn_1) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      width_q <= '0;
      sign_q  <= 1'b0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      gaddr_q <= '0;
      gdata_q <= '0;
      gwen_q  <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      width_q <= width_d;
      sign_q  <= sign_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      req_q   <= req_d;
      gaddr_q <= gaddr_d;
      gdata_q <= gdata_d;
      gwen_q  <= gwen_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_access.sv
// tb_lsu_mem_access: scoreboard bench with a behavioural LSU reference model
module tb_lsu_mem_access;
  localparam int TMO = 4;
  localparam int K_BUS = 0, K_WB = 1, K_MIS = 2, K_BERR = 3;
  typedef struct {int kind; logic [31:0] a; logic [31:0] b; logic [3:0] s; logic we;} ev_t;
  logic        clk = 1'b0, rstn;
  logic        i_Load_1, i_Store_1, i_LoadSign_1, i_MemReady_1;
  logic [1:0]  i_LoadStoreWidth_2;
  logic [31:0] i_Addr_32, i_StoreData_32, i_MemRdata_32;
  logic [4:0]  i_Rd_5;
  logic        o_Stall_1, o_MemReq_1, o_MemWe_1, o_GRFWen_1, o_Misalign_1, o_BusErr_1;
  logic [31:0] o_MemAddr_32, o_MemWdata_32, o_GRFWriteData_32;
  logic [3:0]  o_MemWstrb_4;
  logic [4:0]  o_GRFWriteAddr_5;
  ev_t         q[$];
  int          checks = 0, failures = 0;
  logic        prev_req = 1'b0;
  always #5 clk = ~clk;
  lsu_mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_Clk_1(clk), .i_Rstn_1(rstn), .i_Load_1(i_Load_1), .i_Store_1(i_Store_1),
    .i_LoadSign_1(i_LoadSign_1), .i_LoadStoreWidth_2(i_LoadStoreWidth_2),
    .i_Addr_32(i_Addr_32), .i_StoreData_32(i_StoreData_32), .i_Rd_5(i_Rd_5),
    .o_Stall_1(o_Stall_1), .o_MemReq_1(o_MemReq_1), .o_MemWe_1(o_MemWe_1),
    .o_MemAddr_32(o_MemAddr_32), .o_MemWdata_32(o_MemWdata_32), .o_MemWstrb_4(o_MemWstrb_4),
    .i_MemReady_1(i_MemReady_1), .i_MemRdata_32(i_MemRdata_32),
    .o_GRFWen_1(o_GRFWen_1), .o_GRFWriteAddr_5(o_GRFWriteAddr_5),
    .o_GRFWriteData_32(o_GRFWriteData_32), .o_Misalign_1(o_Misalign_1), .o_BusErr_1(o_BusErr_1)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask
  function automatic logic m_mis(input logic [1:0] w, input logic [31:0] a);
    return w == 2'b10 || (w == 2'b01 && a % 2 != 0) || (w == 2'b11 && a % 4 != 0);
  endfunction
  function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
    return w == 2'b00 ? (d & 32'hFF) * 32'h01010101 :
           w == 2'b01 ? (d & 32'hFFFF) * 32'h00010001 : d;
  endfunction
  function automatic logic [3:0] m_wstrb(input logic ld, input logic [1:0] w, input logic [31:0] a);
    int off = int'(a % 4);
    if (ld) return 4'b0000;
    return w == 2'b00 ? 4'(1 << off) : w == 2'b01 ? 4'(3 << off) : 4'hF;
  endfunction
  function automatic logic [31:0] m_load(input logic [1:0] w, input logic sg, input logic [31:0] a,
                                         input logic [31:0] r);
    int off = int'(a % 4);
    logic [31:0] v;
    if (w == 2'b00) begin
      v = (r >> (8 * off)) & 32'hFF;
      if (sg && v >= 128) v = v - 32'd256;
    end else if (w == 2'b01) begin
      v = (r >> (16 * (off / 2))) & 32'hFFFF;
      if (sg && v >= 32768) v = v - 32'd65536;
    end else v = r;
    return v;
  endfunction
  task automatic chk_ev(input int kind, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s, input logic we);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind %0d a=0x%08h b=0x%08h, expected none", kind, a, b);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.a !== a || e.s !== s || e.we !== we || ((kind == K_WB || we) && e.b !== b)) begin
      failures++;
      $display("FAIL event: got kind %0d a=0x%08h b=0x%08h s=%b we=%b, expected kind %0d a=0x%08h b=0x%08h s=%b we=%b",
               kind, a, b, s, we, e.kind, e.a, e.b, e.s, e.we);
    end
  endtask
  always @(negedge clk) begin
    if (o_MemReq_1 && !prev_req) chk_ev(K_BUS, o_MemAddr_32, o_MemWdata_32, o_MemWstrb_4, o_MemWe_1);
    if (o_GRFWen_1) chk_ev(K_WB, {27'd0, o_GRFWriteAddr_5}, o_GRFWriteData_32, 4'd0, 1'b0);
    if (o_Misalign_1) chk_ev(K_MIS, 32'd0, 32'd0, 4'd0, 1'b0);
    if (o_BusErr_1) chk_ev(K_BERR, 32'd0, 32'd0, 4'd0, 1'b0);
    prev_req = o_MemReq_1;
  end
  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] s, input logic we);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.s = s; e.we = we;
    q.push_back(e);
  endtask
  task automatic drive_idle();
    i_Load_1 = 0; i_Store_1 = 0; i_LoadSign_1 = 0; i_LoadStoreWidth_2 = 0;
    i_Addr_32 = 0; i_StoreData_32 = 0; i_Rd_5 = 0; i_MemReady_1 = 0; i_MemRdata_32 = 0;
  endtask
  task automatic do_op(input logic ld, input logic st, input logic sg, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input int waits, input logic [31:0] rdata);
    int stalls, k, acc;
    logic done, stable, tmo;
    logic [31:0] ba, bd;
    logic [3:0] bs;
    logic bw;
    @(negedge clk);
    i_Load_1 = ld; i_Store_1 = st; i_LoadSign_1 = sg; i_LoadStoreWidth_2 = w;
    i_Addr_32 = a; i_StoreData_32 = d; i_Rd_5 = rd; i_MemReady_1 = 0;
    if (m_mis(w, a)) begin
      push(K_MIS, 0, 0, 0, 0);
      #1 chk("mis_stall", {31'd0, o_Stall_1}, 0);
      @(negedge clk);
      chk("mis_noreq", {31'd0, o_MemReq_1}, 0);
      drive_idle();
      return;
    end
    tmo = waits >= TMO;
    acc = tmo ? TMO : waits + 1;
    push(K_BUS, a & ~32'd3, m_wdata(w, d), m_wstrb(ld, w, a), !ld);
    if (!tmo && ld && rd != 0) push(K_WB, {27'd0, rd}, m_load(w, sg, a, rdata), 0, 0);
    if (tmo) push(K_BERR, 0, 0, 0, 0);
    #1 stalls = o_Stall_1 ? 1 : 0;
    k = 0; done = 0; stable = 1;
    ba = 0; bd = 0; bs = 0; bw = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (o_MemReq_1) begin
        if (o_Stall_1) stalls++;
        if (k == 1) begin
          ba = o_MemAddr_32; bd = o_MemWdata_32; bs = o_MemWstrb_4; bw = o_MemWe_1;
        end else if (ba !== o_MemAddr_32 || bd !== o_MemWdata_32 || bs !== o_MemWstrb_4 || bw !== o_MemWe_1)
          stable = 0;
        i_MemReady_1 = (k - 1 == waits);
        i_MemRdata_32 = i_MemReady_1 ? rdata : $urandom;
        i_Addr_32 = $urandom & ~32'd3;
        i_StoreData_32 = $urandom;
        i_Rd_5 = 5'($urandom);
        i_LoadSign_1 = 1'($urandom);
      end else begin
        done = 1;
        chk("done_stall", {31'd0, o_Stall_1}, 0);
        i_MemReady_1 = 0;
      end
    end
    chk("access_done", {31'd0, done}, 1);
    chk("access_cycles", k - 1, acc);
    chk("stall_cycles", stalls, acc + 1);
    chk("bus_stable", {31'd0, stable}, 1);
    @(negedge clk);
    drive_idle();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    drive_idle();
    rstn = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, o_MemReq_1}, 0);
    chk("rst_we", {31'd0, o_MemWe_1}, 0);
    chk("rst_wstrb", {28'd0, o_MemWstrb_4}, 0);
    chk("rst_addr", o_MemAddr_32, 0);
    chk("rst_wdata", o_MemWdata_32, 0);
    chk("rst_gwen", {31'd0, o_GRFWen_1}, 0);
    chk("rst_gaddr", {27'd0, o_GRFWriteAddr_5}, 0);
    chk("rst_gdata", o_GRFWriteData_32, 0);
    chk("rst_flags", {30'd0, o_Misalign_1, o_BusErr_1}, 0);
    chk("rst_stall", {31'd0, o_Stall_1}, 0);
    rstn = 1;
    do_op(0, 1, 0, 2'b00, 32'h1003, 32'hA5, 0, 0, 0);
    do_op(1, 0, 1, 2'b00, 32'h2001, 32'hAAAA_AAAA, 5, 0, 32'h0000_8000);
    do_op(1, 0, 0, 2'b00, 32'h2001, 32'h0, 5, 1, 32'h0000_8000);
    do_op(1, 0, 1, 2'b01, 32'h2002, 32'h0, 6, 0, 32'h8001_0000);
    do_op(1, 0, 1, 2'b01, 32'h2003, 32'h0, 6, 0, 32'h8001_0000);
    do_op(1, 0, 0, 2'b11, 32'h4000, 32'h0, 0, 3, 32'hDEAD_BEEF);
    do_op(1, 0, 0, 2'b11, 32'h4004, 32'h0, 9, 3, 32'hCAFE_F00D);
    do_op(1, 1, 0, 2'b11, 32'h4008, 32'h1234_5678, 3, 1000, 32'h0);
    do_op(0, 1, 0, 2'b01, 32'h5002, 32'h1234_BEEF, 0, 2, 0);
    // reset during the second ACCESS cycle abandons the load
    @(negedge clk);
    i_Load_1 = 1; i_LoadStoreWidth_2 = 2'b11; i_Addr_32 = 32'h3000; i_Rd_5 = 7;
    push(K_BUS, 32'h3000, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_req_before_rst", {31'd0, o_MemReq_1}, 1);
    rstn = 0;
    drive_idle();
    @(negedge clk);
    chk("mid_rst_req", {31'd0, o_MemReq_1}, 0);
    chk("mid_rst_stall", {31'd0, o_Stall_1}, 0);
    chk("mid_rst_bus", o_MemAddr_32 | o_MemWdata_32 | {28'd0, o_MemWstrb_4} | {31'd0, o_MemWe_1}, 0);
    chk("mid_rst_flags", {29'd0, o_GRFWen_1, o_Misalign_1, o_BusErr_1}, 0);
    rstn = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      int r, wt;
      logic [31:0] a;
      r = $urandom_range(0, 7);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      wt = $urandom_range(0, 4);
      if (wt == 4) wt = 1000;
      do_op(r <= 3, r >= 3, 1'($urandom), 2'($urandom), a, $urandom, 5'($urandom_range(0, 7)),
            wt, $urandom);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
